// File: rtl/lbp_host_mem.sv
// Host-side memory responder for the LBP engine: serves the gray image,
// captures result writes, tracks coverage/duplicates and flags done or timeout.
//
// state | meaning
// IDLE  | after reset, waiting for the first image load write
// LOAD  | image being loaded; img_last moves to SERVE
// SERVE | image valid, engine reads pixels and writes results
// DONE  | run finished (finish or timeout); next img_we starts a new load
module lbp_host_mem #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int NPIX    = 16384,
    parameter int TIMEOUT = 1048576
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              img_we,
    input  logic [ADDR_W-1:0] img_addr,
    input  logic [DATA_W-1:0] img_data,
    input  logic              img_last,
    input  logic              gray_req,
    input  logic [ADDR_W-1:0] gray_addr,
    output logic              gray_ready,
    output logic [DATA_W-1:0] gray_data,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [DATA_W-1:0] lbp_data,
    input  logic              finish,
    input  logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_data,
    output logic              done,
    output logic              timeout,
    output logic [14:0]       wr_count,
    output logic              dup_err,
    output logic              late_err
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TMR_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [14:0]     CNT_MAX  = 15'(NPIX);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SERVE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              gray_ready_q;
    logic              done_q;
    logic              timeout_q;
    logic              dup_q;
    logic              late_q;
    logic [14:0]       wr_count_q;
    logic [TO_W-1:0]   tmr_q;
    logic              hold_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [NPIX-1:0]   written_q;

    logic [DATA_W-1:0] img_mem [NPIX];
    logic [DATA_W-1:0] res_mem [NPIX];

    logic timeout_hit;
    logic enter_load;
    logic serve_wr;
    logic held;

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE:  if (img_we) state_d = S_LOAD;
            S_LOAD:  if (img_we && img_last) state_d = S_SERVE;
            S_SERVE: begin
                // finish takes priority over a coincident terminal count
                if (finish) begin
                    state_d = S_DONE;
                end else if (tmr_q == TMR_LAST) begin
                    state_d     = S_DONE;
                    timeout_hit = 1'b1;
                end
            end
            S_DONE:  if (img_we) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_load = (state_d == S_LOAD) && (state_q != S_LOAD);
    assign serve_wr   = (state_q == S_SERVE) && lbp_valid;
    // A write repeating the previous cycle's accepted address is a held beat
    assign held       = hold_q && (lbp_addr == last_addr_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            gray_ready_q <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            dup_q        <= 1'b0;
            late_q       <= 1'b0;
            wr_count_q   <= '0;
            tmr_q        <= '0;
            hold_q       <= 1'b0;
            last_addr_q  <= '0;
            written_q    <= '0;
        end else begin
            state_q      <= state_d;
            gray_ready_q <= (state_d == S_SERVE);
            done_q       <= (state_d == S_DONE);
            hold_q       <= serve_wr;
            last_addr_q  <= lbp_addr;
            if (state_q != S_SERVE) tmr_q <= '0;
            else                    tmr_q <= tmr_q + 1'b1;

            if (enter_load) begin
                written_q  <= '0;
                wr_count_q <= '0;
                timeout_q  <= 1'b0;
                dup_q      <= 1'b0;
                late_q     <= 1'b0;
            end else begin
                if (timeout_hit) timeout_q <= 1'b1;
                if (serve_wr && !held) begin
                    if (written_q[lbp_addr]) begin
                        dup_q <= 1'b1;
                    end else begin
                        written_q[lbp_addr] <= 1'b1;
                        if (wr_count_q != CNT_MAX) wr_count_q <= wr_count_q + 15'd1;
                    end
                end
                if ((state_q == S_DONE) && lbp_valid) late_q <= 1'b1;
            end
        end
    end

    // Memory contents survive reset and run restarts
    always_ff @(posedge clk) begin
        if (img_we && (state_q != S_SERVE)) img_mem[img_addr] <= img_data;
        if (serve_wr) res_mem[lbp_addr] <= lbp_data;
    end

    assign gray_data  = ((state_q == S_SERVE) && gray_req) ? img_mem[gray_addr] : '0;
    assign res_data   = res_mem[res_addr];
    assign gray_ready = gray_ready_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign wr_count   = wr_count_q;
    assign dup_err    = dup_q;
    assign late_err   = late_q;

endmodule

// File: doc/lbp_host_mem.md
# lbp_host_mem

Host-side responder for the LBP engine's two memory interfaces. It holds the 128x128 gray image and serves it combinationally on the gray read port. It captures the engine's LBP result writes into a result memory, tracks coverage and duplicate writes, and flags completion or timeout. It sits between the testbench/host loader and the LBP engine; results are read back through a separate port.

## Interface
Parameters:
- ADDR_W, 14, pixel address width ({row[6:0], col[6:0]})
- DATA_W, 8, pixel/result width
- NPIX, 16384, pixels per image
- TIMEOUT, 1048576, maximum SERVE cycles before forced DONE

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- img_we  in  1  image load write strobe
- img_addr  in  ADDR_W  image load address
- img_data  in  DATA_W  image load data
- img_last  in  1  qualifies img_we as the final load write
- gray_req  in  1  engine read request
- gray_addr  in  ADDR_W  engine read address
- gray_ready  out  1  image valid; engine may start reading
- gray_data  out  DATA_W  read data, combinational from gray_addr
- lbp_valid  in  1  engine result write strobe
- lbp_addr  in  ADDR_W  result address
- lbp_data  in  DATA_W  result data
- finish  in  1  engine completion level
- res_addr  in  ADDR_W  readback address
- res_data  out  DATA_W  readback data, combinational
- done  out  1  run complete (finish or timeout)
- timeout  out  1  sticky; SERVE exceeded TIMEOUT cycles
- wr_count  out  15  distinct addresses written this run (0..16384)
- dup_err  out  1  sticky; non-consecutive rewrite of an already-written address
- late_err  out  1  sticky; lbp_valid seen in DONE

## Operation
- FSM states: IDLE, LOAD, SERVE, DONE.
  - IDLE: img_we -> LOAD.
  - LOAD: img_we & img_last -> SERVE.
  - SERVE: finish -> DONE; timeout counter == TIMEOUT-1 -> DONE with timeout=1.
  - DONE: img_we -> LOAD.
- Image memory writes:
  - Any img_we in IDLE, LOAD or DONE writes img_mem[img_addr] <= img_data, including the write that triggers the state change.
  - img_we in SERVE is ignored.
- gray_data = img_mem[gray_addr] when state==SERVE and gray_req, else 0. The read is purely combinational, so the engine samples the data at the edge after presenting the address.
- Result capture (SERVE only, on lbp_valid):
  - If lbp_addr equals the last accepted address in the immediately preceding cycle: treat as a held repeat. Rewrite res_mem with the current data; no count change, no error.
  - Otherwise, write res_mem[lbp_addr] <= lbp_data. If written[lbp_addr]==0, set it and increment wr_count. If it was already 1, set dup_err.
  - Track "last accepted address" only across back-to-back valid cycles; a cycle with lbp_valid=0 breaks the hold.
- lbp_valid in DONE: not stored; set late_err. lbp_valid in IDLE/LOAD is ignored.
- Entering LOAD (from IDLE or DONE) clears the written bitmap, wr_count, done, timeout, dup_err and late_err. It does not clear res_mem or img_mem.
- wr_count saturates at NPIX.

## Timing
- Reset (async assert, sync release):
  - state=IDLE.
  - gray_ready=0, done=0, timeout=0, wr_count=0, dup_err=0, late_err=0.
  - written bitmap cleared.
  - Memory contents are not reset. gray_data=0 (state != SERVE).
- Registered outputs:
  - gray_ready=1 exactly while state==SERVE. It rises the cycle after the img_last write and falls the cycle after finish is sampled.
  - done=1 while state==DONE.
- Latency: finish sampled high at edge t -> done=1 and gray_ready=0 after edge t.
- Simultaneous events:
  - lbp_valid and finish in the same cycle: the write is accepted, then DONE.
  - img_we with img_last in IDLE: the write is stored and the next state is LOAD (not SERVE); a further img_last is required.
- Timeout counter:
  - Clears on SERVE entry and increments each SERVE cycle.
  - If finish and the terminal count coincide, finish wins and timeout=0.
- Reset mid-SERVE returns to IDLE immediately; the engine sees gray_ready fall asynchronously.
- res_data is combinational from res_mem[res_addr], valid in all states.

## Test plan
- Load ramp (img_mem[a]=a[7:0]) with img_last on a=16383, then drive gray_req with gray_addr=0x0081 -> gray_ready=1 one cycle after the last load; gray_data=0x81 in the same cycle.
- In SERVE, write all 16384 addresses once each with data=addr[7:0], then assert finish -> wr_count=16384, dup_err=0, done=1 the next cycle, res_data(0x1234)=0x34.
- Drive lbp_valid for 2 consecutive cycles at addr 0x0200 (data 0x5A), then 1 idle cycle, then lbp_valid at 0x0200 again -> wr_count increments once; dup_err=0 after the held pair, dup_err=1 after the third write.
- Assert lbp_valid and finish in the same cycle (addr 0x3FFF, data 0xC3), then lbp_valid one cycle later -> res_data(0x3FFF)=0xC3; late_err=1; wr_count unchanged by the second write.
- TIMEOUT=64, no finish -> done=1 and timeout=1 after 64 SERVE cycles; then an img_we -> LOAD with done=0, timeout=0, wr_count=0.
- Assert reset_n low mid-SERVE -> all outputs return to reset values asynchronously; gray_data=0 regardless of gray_req.
